// File: rtl/spi_fread_chunk_dump_pkg.sv
// Shared types and constants for the chunked fread fetch buffer and its dump path.
// Holds the FSM state encoding, the ASCII codes and the nibble-to-hex helper.
package spi_fread_chunk_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RECV,
    ST_FETCHED,
    ST_DUMP,
    ST_FIN
  } state_e;

  localparam int         REQ_LEN_W = 10;
  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;

  // Uppercase hex digit: '0'..'9' then 'A'..'F'
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/spi_fread_chunk_dump_if.sv
// Request/response link to spi_dev_fread plus the byte-sink handshake toward uart_tx.
// The fetch buffer drives through the master modport; the fread/sink side uses slave.
interface spi_fread_chunk_dump_if;
  import spi_fread_chunk_dump_pkg::*;

  logic [31:0]          req_file_id;
  logic [31:0]          req_offset;
  logic [REQ_LEN_W-1:0] req_len;
  logic                 req_valid;
  logic                 req_ready;
  logic [7:0]           resp_data;
  logic                 resp_valid;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_ack;

  modport master (
    output req_file_id, req_offset, req_len, req_valid,
    input  req_ready,
    input  resp_data, resp_valid,
    output out_data, out_valid,
    input  out_ack
  );

  modport slave (
    input  req_file_id, req_offset, req_len, req_valid,
    output req_ready,
    output resp_data, resp_valid,
    input  out_data, out_valid,
    output out_ack
  );

endinterface

// File: rtl/spi_fread_chunk_dump_byte_hex_fmt.sv
// Expands one buffer byte into its output characters: the raw byte, or two hex digits
// followed by a space or CR/LF when the byte closes a dump line.
module byte_hex_fmt
  import spi_fread_chunk_dump_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hex_mode_i,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  input  logic       eol_i,
  input  logic       step_i,
  output logic [7:0] char_o,
  output logic       vld_o,
  output logic       last_o
);

  logic [7:0] byte_q;
  logic       eol_q;
  logic [1:0] idx_q;
  logic       vld_q;

  // A load always wins over a step: the top reloads exactly when the last char leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      idx_q <= 2'd0;
    end else if (load_i) begin
      vld_q <= 1'b1;
      idx_q <= 2'd0;
    end else if (step_i) begin
      if (last_o) vld_q <= 1'b0;
      else        idx_q <= idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_i) begin
      byte_q <= byte_i;
      eol_q  <= eol_i;
    end
  end

  always_comb begin
    last_o = !hex_mode_i || (eol_q ? (idx_q == 2'd3) : (idx_q == 2'd2));
    char_o = ASCII_LF;
    case (idx_q)
      2'd0:    char_o = hex_mode_i ? hex_ascii(byte_q[7:4]) : byte_q;
      2'd1:    char_o = hex_ascii(byte_q[3:0]);
      2'd2:    char_o = eol_q ? ASCII_CR : ASCII_SP;
      default: char_o = ASCII_LF;
    endcase
  end

  assign vld_o = vld_q;

endmodule

// File: rtl/spi_fread_chunk_dump.sv
// Fetches DEPTH bytes from spi_dev_fread in CHUNK-sized requests into an on-chip buffer,
// then optionally streams the buffer to a byte sink as raw bytes or a hex dump.
module spi_fread_chunk_dump
  import spi_fread_chunk_dump_pkg::*;
#(
  parameter logic [31:0] FILE_ID     = 32'hDABBAD00,
  parameter logic [31:0] BASE_OFFSET = 32'h0,
  parameter int          DEPTH       = 1024,
  parameter int          CHUNK       = 256,
  parameter int          LINE_BYTES  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     dump_en_i,
  input  logic                     hex_mode_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     overrun_o,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [7:0]               rd_data_o,
  spi_fread_chunk_dump_if.master   bus
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          PTR_W   = AW + 1;
  localparam int          NCHUNK  = DEPTH / CHUNK;
  localparam int          CIDX_W  = $clog2(NCHUNK) + 1;
  localparam int          CNT_W   = $clog2(CHUNK) + 1;
  localparam logic [31:0] CHUNK_W = 32'(CHUNK);
  localparam logic [AW-1:0] LB_MASK = AW'(LINE_BYTES - 1);

  if ((DEPTH % CHUNK) != 0 || CHUNK < 1 || CHUNK > 1024 || DEPTH < 2 ||
      (DEPTH & (DEPTH - 1)) != 0 || (LINE_BYTES & (LINE_BYTES - 1)) != 0 ||
      LINE_BYTES > DEPTH) begin : g_param_check
    $error("spi_fread_chunk_dump: illegal DEPTH/CHUNK/LINE_BYTES combination");
  end

  state_e              state_q;
  logic                busy_q, done_q, overrun_q, req_valid_q;
  logic                dump_en_q, hex_q;
  logic [CIDX_W-1:0]   chunk_idx_q;
  logic [CNT_W-1:0]    byte_cnt_q;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    fptr_q, fptr_d, lptr_q, lptr_d;
  logic                rd_vld_q;
  logic [7:0]          rd_q;
  logic [7:0]          out_data_q;
  logic                out_valid_q;
  logic [7:0]          mem [DEPTH];

  logic                start_ok, wr_en, chunk_end;
  logic                fmt_vld, fmt_last, take, load, issue, eol_next, dump_last_ack;
  logic [7:0]          fmt_char;
  logic                rd_en;
  logic [AW-1:0]       rd_addr;

  assign start_ok  = (state_q == ST_IDLE) && start_i;
  assign wr_en     = (state_q == ST_RECV) && bus.resp_valid;
  assign chunk_end = wr_en && (byte_cnt_q == CNT_W'(CHUNK - 1));
  assign wr_ptr_d  = wr_ptr_q + AW'(1);
  assign fptr_d    = fptr_q + PTR_W'(1);
  assign lptr_d    = lptr_q + PTR_W'(1);

  // Dump pipeline: read port -> rd_q slot -> formatter -> sink register.
  // A new read is issued only when the rd_q slot is empty or being drained this cycle.
  assign take          = fmt_vld && (!out_valid_q || bus.out_ack);
  assign load          = rd_vld_q && (!fmt_vld || (take && fmt_last));
  assign issue         = (state_q == ST_DUMP) && (fptr_q < PTR_W'(DEPTH)) && (!rd_vld_q || load);
  assign eol_next      = (lptr_q[AW-1:0] & LB_MASK) == LB_MASK;
  assign dump_last_ack = (lptr_q == PTR_W'(DEPTH)) && !fmt_vld && out_valid_q && bus.out_ack;
  assign rd_en         = (state_q != ST_DUMP) || issue;
  assign rd_addr       = (state_q == ST_DUMP) ? fptr_q[AW-1:0] : rd_addr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      req_valid_q <= 1'b0;
      dump_en_q   <= 1'b0;
      hex_q       <= 1'b0;
      chunk_idx_q <= '0;
      byte_cnt_q  <= '0;
      wr_ptr_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_ok)                                   overrun_q <= 1'b0;
      else if (bus.resp_valid && state_q != ST_RECV)  overrun_q <= 1'b1;
      if (wr_en) wr_ptr_q <= wr_ptr_d;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            busy_q      <= 1'b1;
            dump_en_q   <= dump_en_i;
            hex_q       <= hex_mode_i;
            chunk_idx_q <= '0;
            byte_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            req_valid_q <= 1'b1;
            state_q     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (chunk_end) begin
            byte_cnt_q  <= '0;
            chunk_idx_q <= chunk_idx_q + CIDX_W'(1);
            if (chunk_idx_q == CIDX_W'(NCHUNK - 1)) begin
              state_q <= ST_FETCHED;
            end else begin
              req_valid_q <= 1'b1;
              state_q     <= ST_REQ;
            end
          end else if (wr_en) begin
            byte_cnt_q <= byte_cnt_q + CNT_W'(1);
          end
        end
        ST_FETCHED: begin
          if (dump_en_q) begin
            state_q <= ST_DUMP;
          end else begin
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end
        end
        ST_DUMP: begin
          if (dump_last_ack) begin
            done_q  <= 1'b1;
            state_q <= ST_FIN;
          end
        end
        ST_FIN: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fptr_q      <= '0;
      lptr_q      <= '0;
      rd_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      if (state_q != ST_DUMP) begin
        fptr_q   <= '0;
        lptr_q   <= '0;
        rd_vld_q <= 1'b0;
      end else begin
        if (issue) fptr_q <= fptr_d;
        if (load)  lptr_q <= lptr_d;
        if (issue)     rd_vld_q <= 1'b1;
        else if (load) rd_vld_q <= 1'b0;
      end
      if (take) begin
        out_data_q  <= fmt_char;
        out_valid_q <= 1'b1;
      end else if (bus.out_ack) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Single-write, single-read buffer; read enable keeps a prefetched byte parked in rd_q.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= bus.resp_data;
    if (rd_en) rd_q <= mem[rd_addr];
  end

  byte_hex_fmt u_fmt (
    .clk        (clk),
    .rst_n      (rst_n),
    .hex_mode_i (hex_q),
    .load_i     (load),
    .byte_i     (rd_q),
    .eol_i      (eol_next),
    .step_i     (take),
    .char_o     (fmt_char),
    .vld_o      (fmt_vld),
    .last_o     (fmt_last)
  );

  assign bus.req_file_id = FILE_ID;
  assign bus.req_offset  = BASE_OFFSET + (32'(chunk_idx_q) * CHUNK_W);
  assign bus.req_len     = REQ_LEN_W'(CHUNK - 1);
  assign bus.req_valid   = req_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign overrun_o       = overrun_q;
  assign rd_data_o       = rd_q;

endmodule
